// File: rtl/ahb_sram_responder_pkg.sv
// Shared AHB-Lite slave encodings, responder state enum and byte-lane helper.
package AHP_SLAVE_PKG;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } HTRANS_ENUM;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_ERR1,
    S_ERR2
  } rsp_state_e;

  // Captured address-phase request.
  typedef struct packed {
    logic [17:0] addr;
    logic        write;
    logic [1:0]  size;
  } req_t;

  // Byte-lane enables for a legal (already checked) transfer.
  function automatic logic [NUM_LANES-1:0] lane_be(input logic [1:0] size,
                                                   input logic [1:0] a);
    case (size)
      SIZE_BYTE: lane_be = 4'b0001 << a;
      SIZE_HALF: lane_be = a[1] ? 4'b1100 : 4'b0011;
      default:   lane_be = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_bytelane_mem.sv
// Word SRAM split into byte lanes: per-lane write enable, async read, cleared on reset.
module ahb_sram_bytelane_mem
  import AHP_SLAVE_PKG::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_LANES-1:0]       be_i,
  input  logic [AW-1:0]              idx_i,
  input  logic [NUM_LANES-1:0][7:0]  wdata_i,
  output logic [NUM_LANES-1:0][7:0]  rdata_o
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (be_i[l]) begin
        mem_q[idx_i] <= wdata_i[l];
      end
    end

    assign rdata_o[l] = mem_q[idx_i];
  end

endmodule

// File: rtl/ahb_sram_responder.sv
// AHB-Lite responder for a word SRAM with configurable wait states and ERROR path.
module ahb_sram_responder
  import AHP_SLAVE_PKG::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADYIN,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [1:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int         AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  rsp_state_e                 state_q, state_d;
  logic [2:0]                 cnt_q, cnt_d;
  req_t                       req_q, req_d;
  logic                       accept, addr_err, done;
  logic [NUM_LANES-1:0]       be;
  logic [NUM_LANES-1:0][7:0]  rdata;
  logic                       unused_ok;

  assign unused_ok = ^{HBURST, HADDR[31:18], req_q.addr};

  // Own HREADY gates the accept so a stalled address phase is never taken.
  assign accept = HSEL && HREADYIN && HREADY &&
                  ((HTRANS == NONSEQ) || (HTRANS == SEQ));

  assign addr_err = (HSIZE == 2'b11) ||
                    ((HSIZE == SIZE_HALF) && HADDR[0]) ||
                    ((HSIZE == SIZE_WORD) && (HADDR[1:0] != 2'b00)) ||
                    ({16'b0, HADDR[17:2]} >= 32'(DEPTH));

  assign done = (state_q == S_DATA) && (cnt_q == 3'd0);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      S_DATA:  if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
               else               state_d = S_IDLE;
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      req_d   = '{addr: HADDR[17:0], write: HWRITE, size: HSIZE};
      state_d = addr_err ? S_ERR1 : S_DATA;
      cnt_d   = WS;
    end
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    HRDATA = '0;
    be     = '0;
    case (state_q)
      S_DATA: begin
        HREADY = (cnt_q == 3'd0);
        if (done) begin
          if (req_q.write) be     = lane_be(req_q.size, req_q.addr[1:0]);
          else             HRDATA = rdata;
        end
      end
      S_ERR1: begin
        HREADY = 1'b0;
        HRESP  = HRESP_ERROR;
      end
      S_ERR2:  HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  ahb_sram_bytelane_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .be_i    (be),
    .idx_i   (req_q.addr[AW+1:2]),
    .wdata_i (HWDATA),
    .rdata_o (rdata)
  );

endmodule

// File: doc/ahb_sram_responder.md
Name: ahb_sram_responder

Overview:
AHB-Lite responder fronting a word-organised on-chip SRAM, with a configurable wait-state count and an ERROR response path. It is the memory-side end of the bus that AHP_master drives. It sits behind the top-level HADDR[18] decoder, one instance per slave slot. Its HREADY and HRDATA go back through the top-level response mux, and the muxed HREADY returns on HREADYIN.

Parameters:
DEPTH, 1024, number of 32-bit words; the local word index is HADDR[17:2].
WAIT_STATES, 1, HREADY-low cycles inserted per OKAY data phase; legal range 0..7.

Ports:
HCLK  in  1  bus clock; all state updates on its rising edge
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slot select from the top-level decoder
HREADYIN  in  1  muxed bus HREADY; an address phase is sampled only when this is high
HADDR  in  32  byte address
HTRANS  in  2  HTRANS_ENUM: IDLE, BUSY, NONSEQ, SEQ
HWRITE  in  1  1 = write
HSIZE  in  2  00 byte, 01 halfword, 10 word, 11 unsupported
HBURST  in  3  kept for interface compatibility; no behaviour depends on it
HWDATA  in  32  write data, valid in the data phase
HREADY  out  1  transfer-done / wait indication
HRESP  out  1  0 = OKAY, 1 = ERROR
HRDATA  out  32  read data

Behaviour:
- Reset (asynchronous, effective immediately at any time): state S_IDLE, HREADY=1, HRESP=0, HRDATA=0, wait counter 0, all SRAM words 0. A pending data phase is discarded; its write is not performed.
- Accept condition: HSEL & HREADYIN & (HTRANS==NONSEQ | HTRANS==SEQ), evaluated at a rising edge. On accept, capture addr_q, write_q, size_q.
- IDLE and BUSY transfers, or HSEL=0, are never accepted. The block returns, or stays in, S_IDLE with a zero-wait OKAY.
- Error check at accept time. Any one of these is an error:
  - HSIZE==11
  - halfword with HADDR[0]=1
  - word with HADDR[1:0]!=0
  - HADDR[17:2] >= DEPTH
- States:
  - S_IDLE: HREADY=1, HRESP=0. Accepted and legal -> S_DATA with cnt=WAIT_STATES. Accepted and in error -> S_ERR1. Otherwise stay.
  - S_DATA: HREADY=(cnt==0), HRESP=0. While cnt>0, decrement each cycle.
    - When cnt==0 the transfer completes that cycle.
    - Write completion: HWDATA is written at that edge under byte-lane enables. Byte: the lane given by addr_q[1:0]. Halfword: lanes {2·addr_q[1]+1, 2·addr_q[1]}. Word: all four lanes.
    - Read completion: HRDATA = mem[addr_q[17:2]], full word; the master selects lanes. Outside a read-completion cycle, HRDATA=0.
    - In the completion cycle the block may accept the next address phase (pipelined). Legal -> S_DATA with cnt reloaded. Error -> S_ERR1. None -> S_IDLE.
  - S_ERR1: HREADY=0, HRESP=1. Always -> S_ERR2 next cycle. No SRAM access.
  - S_ERR2: HREADY=1, HRESP=1. New accepts are handled as in S_IDLE.
- Latency:
  - WAIT_STATES=0: data phase completes the cycle after address accept, giving back-to-back single-cycle beats.
  - Otherwise: completion on the (WAIT_STATES+1)th data-phase cycle.
- Read-after-write: a write commits at the end of its completion cycle. A read whose address phase overlaps that cycle returns the new data.
- While HREADY=0, HADDR/HTRANS changes are ignored: no accept is possible.

Decomposition:
- Shared package AHP_SLAVE_PKG holds:
  - HTRANS_ENUM
  - HSIZE encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD)
  - HRESP_OKAY/HRESP_ERROR
  - the responder state enum (S_IDLE, S_DATA, S_ERR1, S_ERR2)
- Sub-module ahb_sram_bytelane_mem: DEPTH×32 array, 4-bit byte write enable, asynchronous read, clear on reset.
- Protocol FSM, error check and wait counter live in the top of this block.

Test Plan:
1. Reset, then IDLE traffic with HSEL=1 -> HREADY=1, HRESP=0, HRDATA=0 on every cycle.
2. WAIT_STATES=1: word write 0xDEADBEEF to 0x010, then word read of 0x010 -> each data phase has exactly one HREADY=0 cycle; read returns HRDATA=0xDEADBEEF.
3. Byte write to 0x011 with HWDATA=0x0000AA00, then word read of 0x010 -> 0xDEADAAEF; halfword write to 0x012 with HWDATA=0x12340000, then read -> 0x1234AAEF.
4. WAIT_STATES=0: INCR4 NONSEQ+3×SEQ word writes 0x11,0x22,0x33,0x44 at 0x020..0x02C, then INCR4 read -> HREADY constant 1; reads return 0x11,0x22,0x33,0x44 on consecutive cycles.
5. Halfword write to 0x013, and separately word read of 0x1000 (DEPTH=1024) -> each gives HREADY=0/HRESP=1 then HREADY=1/HRESP=1; SRAM unchanged; a following legal read returns OKAY with correct data.
6. WAIT_STATES=3: assert HRESETn=0 during the second wait cycle of a write to 0x040 -> HREADY=1/HRESP=0/HRDATA=0 immediately; after release, read of 0x040 returns 0.
